// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter for two requesters, sequencing each write as setup/strobe/release.
// Optional lock mask (locked writes are refused with err) enabled by REG_WR_ARB_LOCK_EN.
module reg_wr_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [2:0]    addr0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [2:0]    addr1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    output logic [2:0]    Addr,
    output logic          WR,
    output logic [DW-1:0] Dout,
    output logic          busy
`ifdef REG_WR_ARB_LOCK_EN
    ,
    input  logic          lock_ld,
    input  logic [7:0]    lock_val,
    output logic          err0,
    output logic          err1
`endif
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
    state_t state, state_nx;
    logic last, win, win_nx, grant, start, locked;
    logic [2:0] addr_g;
    logic [DW-1:0] data_g;
    always_comb begin
        grant = req1 & (~req0 | ~last);
        addr_g = grant ? addr1 : addr0;
        data_g = grant ? data1 : data0;
        start = (state == IDLE) & (req0 | req1);
        win_nx = start ? grant : win;
        state_nx = state == IDLE   ? (start ? (locked ? RELEASE : SETUP) : IDLE) :
                   state == SETUP  ? STROBE :
                   state == STROBE ? RELEASE : IDLE;
    end
    // outputs are registered from the next state so none depends combinationally on inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last <= 1'b1;
            win <= 1'b0;
            Addr <= '0;
            Dout <= '0;
            WR <= 1'b0;
            busy <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            state <= state_nx;
            win <= win_nx;
            WR <= state_nx == STROBE;
            busy <= state_nx != IDLE;
            ack0 <= (state_nx == RELEASE) & ~win_nx;
            ack1 <= (state_nx == RELEASE) & win_nx;
            if (start) begin
                Addr <= addr_g;
                Dout <= data_g;
            end
            if (state == RELEASE) last <= win;
        end
    end
`ifdef REG_WR_ARB_LOCK_EN
    logic [7:0] mask;
    assign locked = mask[addr_g];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            if (lock_ld) mask <= lock_val;
            err0 <= start & locked & ~grant;
            err1 <= start & locked & grant;
        end
    end
`else
    assign locked = 1'b0;
`endif
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: vector table, hand-written corner sequences and a randomized run against a
// transaction-level timeline model of the arbiter.
module tb_reg_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 1500;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic ack0, ack1, WR, busy;
    logic [2:0] Addr;
    logic [DW-1:0] Dout;
`ifdef REG_WR_ARB_LOCK_EN
    logic lock_ld = 1'b0;
    logic [7:0] lock_val = '0;
    logic err0, err1;
`endif
    reg_wr_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .Addr(Addr), .WR(WR), .Dout(Dout), .busy(busy)
`ifdef REG_WR_ARB_LOCK_EN
        , .lock_ld(lock_ld), .lock_val(lock_val), .err0(err0), .err1(err1)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    typedef struct {
        logic r0, r1;
        logic [2:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic w;
        logic [2:0] ea;
        logic [DW-1:0] ed;
    } vec_t;
    vec_t tbl[7];
    // called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the write
    task automatic run_vec(input vec_t v);
        req0 = v.r0; req1 = v.r1;
        addr0 = v.a0; addr1 = v.a1;
        data0 = v.d0; data1 = v.d1;
        @(negedge clk);
        chk("setup_addr", 32'(Addr), 32'(v.ea));
        chk("setup_dout", 32'(Dout), 32'(v.ed));
        chk("setup_busy", 32'(busy), 1);
        chk("setup_wr", 32'(WR), 0);
        if (v.w) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        chk("strobe_wr", 32'(WR), 1);
        chk("strobe_acks", 32'({ack1, ack0}), 0);
        chk("strobe_addr", 32'(Addr), 32'(v.ea));
        @(negedge clk);
        chk("release_ack0", 32'(ack0), 32'(!v.w));
        chk("release_ack1", 32'(ack1), 32'(v.w));
        chk("release_wr", 32'(WR), 0);
        chk("release_dout", 32'(Dout), 32'(v.ed));
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_acks", 32'({ack1, ack0}), 0);
        chk("idle_addr_hold", 32'(Addr), 32'(v.ea));
    endtask
    int wr_prev;
    int grants[$];
    bit e_busy[NR + 4];
    bit e_wr[NR + 4];
    logic [1:0] e_ack[NR + 4];
    initial begin
        tbl[0] = '{1'b0, 1'b1, 3'd0, 3'd7, 8'h00, 8'h3C, 1'b1, 3'd7, 8'h3C};
        tbl[1] = '{1'b1, 1'b1, 3'd1, 3'd2, 8'h11, 8'h22, 1'b0, 3'd1, 8'h11};
        tbl[2] = '{1'b1, 1'b0, 3'd5, 3'd0, 8'hA5, 8'h00, 1'b0, 3'd5, 8'hA5};
        tbl[3] = '{1'b1, 1'b1, 3'd3, 3'd4, 8'h33, 8'h44, 1'b1, 3'd4, 8'h44};
        tbl[4] = '{1'b1, 1'b1, 3'd6, 3'd0, 8'h66, 8'h00, 1'b0, 3'd6, 8'h66};
        tbl[5] = '{1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 8'hFF, 1'b1, 3'd0, 8'hFF};
        tbl[6] = '{1'b1, 1'b1, 3'd7, 3'd6, 8'h77, 8'h5A, 1'b0, 3'd7, 8'h77};
        #3;
        chk("rst_addr", 32'(Addr), 0);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_wr", 32'(WR), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'({ack1, ack0}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);
        // reset pulse in the middle of a strobe
        req0 = 1'b1; addr0 = 3'd3; data0 = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr_before", 32'(WR), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_wr", 32'(WR), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_acks", 32'({ack1, ack0}), 0);
        req0 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'({ack1, ack0}), 0);
        end
        // lone req1 with last=1 after reset, then contention must start with requester 0
        run_vec('{1'b0, 1'b1, 3'd0, 3'd4, 8'h00, 8'h77, 1'b1, 3'd4, 8'h77});
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 3'd1; addr1 = 3'd2; data0 = 8'h01; data1 = 8'h02;
        wr_prev = -1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (WR) begin
                if (wr_prev >= 0) chk("wr_spacing", 32'(c - wr_prev), 4);
                wr_prev = c;
            end
            if (ack0 && ack1) chk("ack_overlap", 32'({ack1, ack0}), 1);
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        chk("contend_count", 32'(grants.size()), 5);
        foreach (grants[i]) chk("contend_order", 32'(grants[i]), 32'(i % 2));
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        // randomized run against a timeline model
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        begin
            int free_at = 0;
            logic m_last = 1'b1;
            logic w;
            logic [2:0] m_addr = '0;
            logic [DW-1:0] m_dout = '0;
            for (int k = 0; k < NR; k++) begin
                @(posedge clk);
                if (k >= free_at && (req0 || req1)) begin
                    w = (req0 && req1) ? !m_last : req1;
                    m_addr = w ? addr1 : addr0;
                    m_dout = w ? data1 : data0;
                    for (int j = 0; j < 3; j++) e_busy[k + j] = 1'b1;
                    e_wr[k + 1] = 1'b1;
                    e_ack[k + 2] = w ? 2'b10 : 2'b01;
                    m_last = w;
                    free_at = k + 4;
                end
                @(negedge clk);
                chk("rnd_busy", 32'(busy), 32'(e_busy[k]));
                chk("rnd_wr", 32'(WR), 32'(e_wr[k]));
                chk("rnd_acks", 32'({ack1, ack0}), 32'(e_ack[k] === 2'bxx ? 2'b00 : e_ack[k]));
                chk("rnd_addr", 32'(Addr), 32'(m_addr));
                chk("rnd_dout", 32'(Dout), 32'(m_dout));
                if (req0 && ack0) req0 = ($urandom_range(3) == 0);
                else if (!req0) begin
                    addr0 = 3'($urandom); data0 = DW'($urandom);
                    req0 = ($urandom_range(2) == 0);
                end
                if (req1 && ack1) req1 = ($urandom_range(3) == 0);
                else if (!req1) begin
                    addr1 = 3'($urandom); data1 = DW'($urandom);
                    req1 = ($urandom_range(2) == 0);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) @(negedge clk);
`ifdef REG_WR_ARB_LOCK_EN
        lock_ld = 1'b1; lock_val = 8'h08;
        @(negedge clk) lock_ld = 1'b0;
        req0 = 1'b1; addr0 = 3'd3; data0 = 8'hC3;
        @(negedge clk);
        chk("lock_ack0", 32'(ack0), 1);
        chk("lock_err0", 32'(err0), 1);
        chk("lock_wr", 32'(WR), 0);
        req0 = 1'b0;
        @(negedge clk);
        chk("lock_idle", 32'(busy), 0);
        req0 = 1'b1; addr0 = 3'd4; data0 = 8'h4C;
        @(negedge clk);
        @(negedge clk);
        chk("unlock_wr", 32'(WR), 1);
        @(negedge clk);
        chk("unlock_ack0", 32'(ack0), 1);
        chk("unlock_err0", 32'(err0), 0);
        req0 = 1'b0;
        @(negedge clk);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
